// File: rtl/pll_ctrl_pkg.sv
// Shared definitions for PLL bring-up control: FSM state encoding and default timing.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package pll_ctrl_pkg;

  // FSM state encoding, exported on the debug state port
  typedef enum logic [2:0] {
    RESET_PLL = 3'd0,
    WAIT_LOCK = 3'd1,
    STABILIZE = 3'd2,
    RUN       = 3'd3,
    FAIL      = 3'd4
  } pll_state_e;

  // Default timing in refclk cycles
  localparam int DEF_RST_CYCLES    = 32;
  localparam int DEF_LOCK_TIMEOUT  = 65536;
  localparam int DEF_STABLE_CYCLES = 1024;
  localparam int DEF_MAX_RETRIES   = 3;
  localparam int DEF_CNT_W         = 17;

endpackage

// File: rtl/sync2.sv
// Generic 2-flop synchronizer for level signals crossing into clk.
// Latency: 2 clk cycles from a sampled input change to q.
// Backpressure: none; continuously samples d.
module sync2 #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  // Two-stage capture; first stage may go metastable, second is used downstream
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pll_lock_supervisor.sv
// Sequences PLL reset, lock wait with timeout/retry, lock qualification and loss-of-lock restart.
// Latency: pll_locked reaches decisions 2 cycles after sampling; all outputs registered.
// Backpressure: none; restart pulse is accepted every cycle and overrides all transitions.
module pll_lock_supervisor
  import pll_ctrl_pkg::*;
#(
  parameter int RST_CYCLES    = DEF_RST_CYCLES,
  parameter int LOCK_TIMEOUT  = DEF_LOCK_TIMEOUT,
  parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int MAX_RETRIES   = DEF_MAX_RETRIES,
  parameter int CNT_W         = DEF_CNT_W
) (
  input  logic       refclk,
  input  logic       rst_n,
  input  logic       pll_locked,
  input  logic       restart,
  output logic       pll_rst,
  output logic       clocks_ready,
  output logic       lock_lost,
  output logic       fail,
  output logic [1:0] retry_cnt,
  output logic [2:0] state
);

  localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [1:0]       RETRY_LIMIT  = 2'(MAX_RETRIES);

  pll_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       retry_d;
  logic             lock_lost_d;
  logic             fail_d;
  logic             lk_s;

  sync2 #(.W(1)) u_lock_sync (
    .clk   (refclk),
    .rst_n (rst_n),
    .d     (pll_locked),
    .q     (lk_s)
  );

  assign state = state_q;

  // Next-state, shared counter and retry bookkeeping; restart overrides everything
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    retry_d     = retry_cnt;
    lock_lost_d = 1'b0;
    if (restart) begin
      state_d = RESET_PLL;
      cnt_d   = '0;
      retry_d = '0;
    end else begin
      case (state_q)
        RESET_PLL: begin
          if (cnt_q == RST_LAST) begin
            state_d = WAIT_LOCK;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        WAIT_LOCK: begin
          if (lk_s) begin
            state_d = STABILIZE;
            cnt_d   = '0;
          end else if (cnt_q == TIMEOUT_LAST) begin
            cnt_d = '0;
            if (retry_cnt == RETRY_LIMIT) begin
              state_d = FAIL;
            end else begin
              state_d = RESET_PLL;
              retry_d = (retry_cnt == 2'd3) ? 2'd3 : retry_cnt + 2'd1;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        STABILIZE: begin
          // A dropout restarts the lock wait but does not consume a retry
          if (!lk_s) begin
            state_d = WAIT_LOCK;
            cnt_d   = '0;
          end else if (cnt_q == STABLE_LAST) begin
            state_d = RUN;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        RUN: begin
          if (!lk_s) begin
            state_d     = RESET_PLL;
            cnt_d       = '0;
            retry_d     = '0;
            lock_lost_d = 1'b1;
          end
        end
        FAIL: begin
          state_d = FAIL;
        end
        default: begin
          state_d = RESET_PLL;
          cnt_d   = '0;
        end
      endcase
    end
    fail_d = (state_d == FAIL);
  end

  // State, counter and output registers; pll_rst/clocks_ready decoded from next state
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= RESET_PLL;
      cnt_q        <= '0;
      retry_cnt    <= '0;
      fail         <= 1'b0;
      lock_lost    <= 1'b0;
      pll_rst      <= 1'b1;
      clocks_ready <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      retry_cnt    <= retry_d;
      fail         <= fail_d;
      lock_lost    <= lock_lost_d;
      pll_rst      <= (state_d == RESET_PLL) || (state_d == FAIL);
      clocks_ready <= (state_d == RUN);
    end
  end

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Directed bench: stimulus queues expected output-change events, a monitor checks them.
// Latency: n/a.
// Backpressure: n/a.
module tb_pll_lock_supervisor;

  logic       refclk = 1'b0;
  logic       rst_n;
  logic       pll_locked;
  logic       restart;
  logic       pll_rst;
  logic       clocks_ready;
  logic       lock_lost;
  logic       fail;
  logic [1:0] retry_cnt;
  logic [2:0] state;

  pll_lock_supervisor #(
    .RST_CYCLES    (4),
    .LOCK_TIMEOUT  (16),
    .STABLE_CYCLES (8),
    .MAX_RETRIES   (3),
    .CNT_W         (17)
  ) dut (
    .refclk       (refclk),
    .rst_n        (rst_n),
    .pll_locked   (pll_locked),
    .restart      (restart),
    .pll_rst      (pll_rst),
    .clocks_ready (clocks_ready),
    .lock_lost    (lock_lost),
    .fail         (fail),
    .retry_cnt    (retry_cnt),
    .state        (state)
  );

  always #5 refclk = ~refclk;

  // Posedge counter: the event stamp is the index of the edge that produced a change
  int cyc = 0;
  always @(posedge refclk) cyc <= cyc + 1;

  // Output tuple: {pll_rst, clocks_ready, lock_lost, fail, retry_cnt[1:0], state[2:0]}
  typedef struct {
    int         cyc;
    logic [8:0] v;
  } ev_t;

  ev_t        exp_q[$];
  int         vectors     = 0;
  int         miscompares = 0;
  logic [8:0] prev        = 'x;
  logic [8:0] cur;
  ev_t        ev;

  function automatic void push(input int c, input logic prst, input logic rdy,
                               input logic lost, input logic f,
                               input logic [1:0] rc, input logic [2:0] st);
    ev_t e;
    e.cyc = c;
    e.v   = {prst, rdy, lost, f, rc, st};
    exp_q.push_back(e);
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge refclk);
    #1;
  endtask

  // Monitor: each change of the output tuple must match the next queued event
  always @(negedge refclk) begin
    cur = {pll_rst, clocks_ready, lock_lost, fail, retry_cnt, state};
    if (cur !== prev) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_change at cycle %0d: outputs %b, required no change", cyc, cur);
      end else begin
        ev = exp_q.pop_front();
        if (cyc != ev.cyc || cur !== ev.v) begin
          miscompares++;
          $display("FAIL event {rst,rdy,lost,fail,retry,state}: got cycle %0d outputs %b, required cycle %0d outputs %b",
                   cyc, cur, ev.cyc, ev.v);
        end
      end
      prev = cur;
    end
  end

  int b;

  initial begin
    rst_n      = 1'b0;
    pll_locked = 1'b0;
    restart    = 1'b0;

    // Reset state, then release and first lock
    push(1, 1, 0, 0, 0, 2'd0, 3'd0);
    tick(3);
    b = cyc;
    rst_n = 1'b1;
    push(b + 4, 0, 0, 0, 0, 2'd0, 3'd1);          // 4-cycle pll_rst
    tick(9);
    pll_locked = 1'b1;
    b = cyc + 1;                                  // edge that samples the lock
    push(b + 2,  0, 0, 0, 0, 2'd0, 3'd2);
    push(b + 10, 0, 1, 0, 0, 2'd0, 3'd3);         // 2 sync + 8 qualify
    tick(12);

    // One-cycle lock drop in RUN
    pll_locked = 1'b0;
    b = cyc + 1;
    tick(1);
    pll_locked = 1'b1;
    push(b + 2,  1, 0, 1, 0, 2'd0, 3'd0);         // lock_lost pulse, back to reset
    push(b + 3,  1, 0, 0, 0, 2'd0, 3'd0);
    push(b + 6,  0, 0, 0, 0, 2'd0, 3'd1);
    push(b + 7,  0, 0, 0, 0, 2'd0, 3'd2);
    // Glitch while the stable counter holds 5: full requalification follows
    tick(10);
    pll_locked = 1'b0;
    tick(1);
    pll_locked = 1'b1;
    push(b + 13, 0, 0, 0, 0, 2'd0, 3'd1);
    push(b + 14, 0, 0, 0, 0, 2'd0, 3'd2);
    push(b + 22, 0, 1, 0, 0, 2'd0, 3'd3);
    tick(12);

    // Restart coincident with a lock drop in RUN: no lock_lost
    b = cyc;
    pll_locked = 1'b0;
    tick(2);
    restart = 1'b1;
    tick(1);
    restart = 1'b0;
    push(b + 3, 1, 0, 0, 0, 2'd0, 3'd0);
    push(b + 7, 0, 0, 0, 0, 2'd0, 3'd1);

    // Lock never arrives: three retries, then FAIL
    b = b + 7;
    for (int k = 0; k < 3; k++) begin
      push(b + 20*k + 16, 1, 0, 0, 0, 2'(k + 1), 3'd0);
      push(b + 20*k + 20, 0, 0, 0, 0, 2'(k + 1), 3'd1);
    end
    push(b + 76, 1, 0, 0, 1, 2'd3, 3'd4);
    tick(84);
    restart = 1'b1;
    b = cyc;
    tick(1);
    restart = 1'b0;
    push(b + 1, 1, 0, 0, 0, 2'd0, 3'd0);          // fail and retry_cnt cleared
    push(b + 5, 0, 0, 0, 0, 2'd0, 3'd1);
    tick(4);

    // Async reset in mid-STABILIZE
    pll_locked = 1'b1;
    b = cyc + 1;
    push(b + 2, 0, 0, 0, 0, 2'd0, 3'd2);
    tick(6);
    push(cyc, 1, 0, 0, 0, 2'd0, 3'd0);            // same cycle: asynchronous
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    b = cyc;
    push(b + 4,  0, 0, 0, 0, 2'd0, 3'd1);
    push(b + 5,  0, 0, 0, 0, 2'd0, 3'd2);
    push(b + 13, 0, 1, 0, 0, 2'd0, 3'd3);
    tick(16);

    // Async reset in mid-RUN, then recovery
    push(cyc, 1, 0, 0, 0, 2'd0, 3'd0);
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    b = cyc;
    push(b + 4,  0, 0, 0, 0, 2'd0, 3'd1);
    push(b + 5,  0, 0, 0, 0, 2'd0, 3'd2);
    push(b + 13, 0, 1, 0, 0, 2'd0, 3'd3);
    tick(16);

    // Every queued event must have been observed
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL pending_events: got %0d unobserved, required 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
